inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, meaning the single clock (all state on rising edge).
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port inst_ifu_valid_i, input, 1, meaning ifu offers an instruction.
REQ-005 SHALL have port pc_ifu_i, input, 32, meaning PC of the offered instruction.
REQ-006 SHALL have port inst_data_ifu_i, input, 32, meaning the offered instruction word.
REQ-007 SHALL have port ifq_ready_o, input-side ready, output, 1, meaning the queue can accept.
REQ-008 SHALL have port inst_id_valid_o, output, 1, meaning the head entry is valid for id.
REQ-009 SHALL have port pc_id_o, output, 32, meaning the head PC.
REQ-010 SHALL have port inst_data_id_o, output, 32, meaning the head instruction.
REQ-011 SHALL have port id_ready_i, input, 1, meaning id consumes the head this cycle.
REQ-012 SHALL have port hold_flag_i, input, 1, meaning ex stall; blocks pop.
REQ-013 SHALL have port jump_flag_i, input, 1, meaning redirect; flushes the queue.
REQ-014 SHALL have port ifq_count_o, output, clog2(DEPTH)+1, meaning occupancy.

Function
REQ-015 SHALL push when inst_ifu_valid_i && ifq_ready_o && !jump_flag_i, storing {pc, inst} at the write pointer.
REQ-016 SHALL drive ifq_ready_o = (count < DEPTH), combinationally from registered count only.
REQ-017 SHALL pop when inst_id_valid_o && id_ready_i && !hold_flag_i.
REQ-018 SHALL drive inst_id_valid_o = (count != 0) and pc_id_o/inst_data_id_o from the read pointer; when count == 0, pc_id_o = 0 and inst_data_id_o = NOP 32'h0000_0013.
REQ-019 SHALL give one-cycle latency: a word pushed in cycle N is visible at the head in cycle N+1 at the earliest.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL wrap read/write pointers modulo DEPTH without loss; no push when full, no pop when empty.
REQ-022 SHALL, when jump_flag_i is high, set count and both pointers to 0 on the next edge, discarding the incoming word and all stored entries; a pop in that cycle counts as consumed by id.
REQ-023 SHALL keep head outputs stable while inst_id_valid_o is high and no pop occurs.
REQ-024 SHALL treat hold_flag_i only as a pop inhibit; pushes continue until full.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously clear count and pointers, giving inst_id_valid_o = 0, pc_id_o = 0, inst_data_id_o = 32'h0000_0013, ifq_count_o = 0, ifq_ready_o = 1.
REQ-026 SHALL not require storage array reset; contents are invalid until written.
REQ-027 SHALL discard any in-flight push or pop when reset asserts mid-operation.

Configuration
REQ-028 SHALL support macro IFQ_BYPASS_EN: when defined, if count == 0, inst_ifu_valid_i is high, pop conditions hold and no jump, the input word SHALL appear on the head outputs in the same cycle and not be stored (zero latency); without it, REQ-019 latency applies always.

Structure
REQ-029 SHALL take NOP constant, 32-bit address/data widths and the entry typedef {pc, inst} from the shared core package rv_core_pkg.
REQ-030 SHALL keep storage inline; no sub-module is required.

Verification
REQ-031 SHALL verify: reset, push pc=0x0/inst=0x00500093 with id_ready_i=1 -> head valid next cycle with those values, count 1 then 0 (bypass off).
REQ-032 SHALL verify: 4 pushes with id_ready_i=0 -> count 4, ifq_ready_o=0, 5th offer held by ifu; then 4 pops return PCs 0x0,0x4,0x8,0xC in order.
REQ-033 SHALL verify: 10 push/pop cycles at count 2 -> count stays 2, PCs in order across pointer wrap.
REQ-034 SHALL verify: count 3, jump_flag_i=1 with a push offered -> next cycle count 0, inst_id_valid_o=0, inst_data_id_o=0x00000013.
REQ-035 SHALL verify: hold_flag_i=1 with id_ready_i=1 for 3 cycles -> head unchanged, no pop; pushes still accepted.
REQ-036 SHALL verify: with IFQ_BYPASS_EN, empty queue, push pc=0x20 with id_ready_i=1 -> pc_id_o=0x20 same cycle, count stays 0.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths, NOP encoding and fetch-queue entry type
package rv_core_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } ifq_entry_t;
endpackage

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: IFU->ID instruction FIFO with flush on jump; IFQ_BYPASS_EN enables zero-latency pass-through when empty
module inst_fetch_queue
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        inst_ifu_valid_i,
   input  logic [XLEN-1:0]             pc_ifu_i,
   input  logic [XLEN-1:0]             inst_data_ifu_i,
   output logic                        ifq_ready_o,
   output logic                        inst_id_valid_o,
   output logic [XLEN-1:0]             pc_id_o,
   output logic [XLEN-1:0]             inst_data_id_o,
   input  logic                        id_ready_i,
   input  logic                        hold_flag_i,
   input  logic                        jump_flag_i,
   output logic [$clog2(DEPTH):0]      ifq_count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ifq_entry_t    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty, byp, push, pop;

   // handshake decode, head muxing and next pointer/count state
   always_comb begin
      empty       = count_q == '0;
      ifq_ready_o = count_q < CW'(DEPTH);
`ifdef IFQ_BYPASS_EN
      byp = empty && inst_ifu_valid_i && id_ready_i && !hold_flag_i && !jump_flag_i;
`else
      byp = 1'b0;
`endif
      push            = inst_ifu_valid_i && ifq_ready_o && !jump_flag_i && !byp;
      pop             = !empty && id_ready_i && !hold_flag_i;
      inst_id_valid_o = !empty || byp;
      pc_id_o         = byp ? pc_ifu_i : empty ? '0 : mem_q[rd_ptr_q].pc;
      inst_data_id_o  = byp ? inst_data_ifu_i : empty ? NOP : mem_q[rd_ptr_q].inst;
      ifq_count_o     = count_q;
      rd_ptr_d        = jump_flag_i ? '0 : rd_ptr_q + AW'(pop);
      wr_ptr_d        = jump_flag_i ? '0 : wr_ptr_q + AW'(push);
      count_d         = jump_flag_i ? '0 : count_q + CW'(push) - CW'(pop);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // entry storage, unreset: contents only read once counted valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{pc: pc_ifu_i, inst: inst_data_ifu_i};
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue (default build; bypass case under IFQ_BYPASS_EN)
module tb_inst_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_ifu_valid_i;
   logic [31:0] pc_ifu_i;
   logic [31:0] inst_data_ifu_i;
   logic        ifq_ready_o;
   logic        inst_id_valid_o;
   logic [31:0] pc_id_o;
   logic [31:0] inst_data_id_o;
   logic        id_ready_i;
   logic        hold_flag_i;
   logic        jump_flag_i;
   logic [2:0]  ifq_count_o;
   int          checks = 0;
   int          errors = 0;

   inst_fetch_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_ifu_valid_i(inst_ifu_valid_i), .pc_ifu_i(pc_ifu_i), .inst_data_ifu_i(inst_data_ifu_i),
      .ifq_ready_o(ifq_ready_o), .inst_id_valid_o(inst_id_valid_o),
      .pc_id_o(pc_id_o), .inst_data_id_o(inst_data_id_o),
      .id_ready_i(id_ready_i), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
      .ifq_count_o(ifq_count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance one clock, land 1ns after the edge so new inputs can be driven
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic hold, input logic jmp);
      inst_ifu_valid_i = v;
      pc_ifu_i         = pc;
      inst_data_ifu_i  = 32'h0050_0093 + pc;
      id_ready_i       = rdy;
      hold_flag_i      = hold;
      jump_flag_i      = jmp;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      #10;
      check("rst_valid", 32'(inst_id_valid_o), 0);
      check("rst_pc", pc_id_o, 0);
      check("rst_inst", inst_data_id_o, 32'h0000_0013);
      check("rst_count", 32'(ifq_count_o), 0);
      check("rst_ready", 32'(ifq_ready_o), 1);
      @(negedge clk) rst_n = 1'b1;
      step();
      // single push with id ready: head valid next cycle, then drained
      drive(1, 32'h0, 1, 0, 0);
`ifndef IFQ_BYPASS_EN
      check("t1_no_same_cycle", 32'(inst_id_valid_o), 0);
      step();
      drive(0, 0, 1, 0, 0);
      check("t1_valid", 32'(inst_id_valid_o), 1);
      check("t1_pc", pc_id_o, 32'h0);
      check("t1_inst", inst_data_id_o, 32'h0050_0093);
      check("t1_count1", 32'(ifq_count_o), 1);
`endif
      step();
      drive(0, 0, 0, 0, 0);
      check("t1_count0", 32'(ifq_count_o), 0);
      // fill to full with id stalled, fifth offer must be refused
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'(4 * i), 0, 0, 0);
         step();
      end
      drive(1, 32'h10, 0, 0, 0);
      check("t2_full_count", 32'(ifq_count_o), 4);
      check("t2_not_ready", 32'(ifq_ready_o), 0);
      step();
      drive(0, 0, 1, 0, 0);
      check("t2_fifth_held", 32'(ifq_count_o), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_pop_pc%0d", i), pc_id_o, 32'(4 * i));
         step();
      end
      drive(0, 0, 0, 0, 0);
      check("t2_empty", 32'(ifq_count_o), 0);
      // steady push+pop at occupancy 2 across pointer wrap
      drive(1, 32'h100, 0, 0, 0);
      step();
      drive(1, 32'h104, 0, 0, 0);
      step();
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h108 + 32'(4 * i), 1, 0, 0);
         check($sformatf("t3_pc%0d", i), pc_id_o, 32'h100 + 32'(4 * i));
         step();
      end
      drive(0, 0, 0, 0, 0);
      check("t3_count", 32'(ifq_count_o), 2);
      check("t3_inst", inst_data_id_o, 32'h0050_0093 + 32'h128);
      // count 3 then jump with a push offered: everything discarded
      drive(1, 32'h300, 0, 0, 0);
      step();
      drive(1, 32'h304, 1, 0, 1);
      check("t4_count3", 32'(ifq_count_o), 3);
      step();
      drive(0, 0, 0, 0, 0);
      check("t4_flush_count", 32'(ifq_count_o), 0);
      check("t4_flush_valid", 32'(inst_id_valid_o), 0);
      check("t4_flush_inst", inst_data_id_o, 32'h0000_0013);
      check("t4_flush_pc", pc_id_o, 0);
      // hold blocks pop while pushes keep landing
      drive(1, 32'h200, 0, 0, 0);
      step();
      for (int i = 1; i < 4; i++) begin
         drive(1, 32'h200 + 32'(4 * i), 1, 1, 0);
         check($sformatf("t5_hold_pc%0d", i), pc_id_o, 32'h200);
         step();
      end
      drive(0, 0, 1, 0, 0);
      check("t5_count", 32'(ifq_count_o), 4);
      check("t5_head", pc_id_o, 32'h200);
      step();
      drive(0, 0, 0, 0, 0);
      check("t5_next", pc_id_o, 32'h204);
      check("t5_count_after", 32'(ifq_count_o), 3);
`ifdef IFQ_BYPASS_EN
      drive(0, 0, 0, 0, 1);
      step();
      drive(1, 32'h20, 1, 0, 0);
      check("t6_byp_valid", 32'(inst_id_valid_o), 1);
      check("t6_byp_pc", pc_id_o, 32'h20);
      step();
      drive(0, 0, 0, 0, 0);
      check("t6_byp_count", 32'(ifq_count_o), 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
